// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// default width, funct3 op encodings, FSM states and operand-sign decode.
package muldiv_sequencer_pkg;

  localparam int MULDIV_N = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic rs1_signed(input logic [2:0] f);
    return f[2] ? ~f[0] : (f != F3_MULHU);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f);
    return f[2] ? ~f[0] : ~f[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: shift-add multiply or restoring
// shift-subtract divide on the {hi, lo} working pair.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int N = MULDIV_N
) (
  input  logic         is_mul_i,
  input  logic [N-1:0] hi_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  logic [N:0]   sum;
  logic [N:0]   sh;
  logic [N-1:0] diff;
  logic         ge;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    sh   = {hi_i, lo_i[N-1]};
    ge   = sh >= {1'b0, b_i};
    // Only consumed when ge, so the low N bits are exact.
    diff = sh[N-1:0] - b_i;
    if (is_mul_i) begin
      hi_o = sum[N:1];
      lo_o = {sum[0], lo_i[N-1:1]};
    end else begin
      hi_o = ge ? diff : sh[N-1:0];
      lo_o = {lo_i[N-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: sign handling,
// special-case shortcuts and N-step iteration through muldiv_step.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int N = MULDIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_e        state_q, state_d;
  funct3_e       op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;

  logic [N-1:0]   step_hi, step_lo;
  logic           sa_in, sb_in;
  logic [N-1:0]   ma, mb;
  logic [2*N-1:0] prod;

  muldiv_step #(.N(N)) u_step (
    .is_mul_i (~op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    sa_in = rs1_signed(funct3) & rs1[N-1];
    sb_in = rs2_signed(funct3) & rs2[N-1];
    ma    = sa_in ? -rs1 : rs1;
    mb    = sb_in ? -rs2 : rs2;
    prod  = {hi_q, lo_q};
    if (sa_q ^ sb_q) prod = -prod;

    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    unique case (state_q)
      S_IDLE: if (start) begin
        op_d  = funct3_e'(funct3);
        sa_d  = sa_in;
        sb_d  = sb_in;
        cnt_d = '0;
        if (funct3[2] && rs2 == '0) begin
          res_d   = funct3[1] ? rs1 : '1;
          state_d = S_DONE;
        end else if (funct3[2] && !funct3[0] &&
                     rs1 == MIN_NEG && rs2 == '1) begin
          res_d   = funct3[1] ? '0 : rs1;
          state_d = S_DONE;
        end else begin
          hi_d    = '0;
          lo_d    = funct3[2] ? ma : mb;
          b_d     = funct3[2] ? mb : ma;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[2])
          res_d = (op_q == F3_MUL) ? prod[N-1:0] : prod[2*N-1:N];
        else if (op_q[1])
          res_d = sa_q ? -hi_q : hi_q;
        else
          res_d = (sa_q ^ sb_q) ? -lo_q : lo_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= F3_MUL;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = res_q;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new M-extension operation.
REQ-005 SHALL have port flush  input  1  pipeline flush; abort any operation in progress.
REQ-006 SHALL have port funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port rs1  input  N  multiplicand/dividend.
REQ-008 SHALL have port rs2  input  N  multiplier/divisor.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE; used as pipeline stall.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL have port result  output  N  final value; held stable from done until the next accepted start.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX, DONE.
REQ-013 In IDLE with start=1 and flush=0: SHALL capture funct3, absolute values of signed operands and sign flags, clear the iteration counter, go to RUN.
REQ-014 RUN SHALL perform exactly N iterations, one per cycle, then go to FIX.
REQ-015 Multiply iteration: SHALL add multiplicand to the upper half of a 2N-bit product register if the current LSB is 1, then shift right by 1.
REQ-016 Divide iteration (restoring): SHALL shift {remainder, quotient} left by 1, subtract divisor from remainder, keep difference and set quotient LSB to 1 if non-negative, else restore and set 0.
REQ-017 FIX SHALL apply two's-complement sign correction and select: MUL low N bits; MULH/MULHSU/MULHU high N bits; DIV/DIVU quotient; REM/REMU remainder (remainder sign = dividend sign); then go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-019 Normal latency: done SHALL be high exactly N+2 cycles after the start cycle.
REQ-020 Divide by zero SHALL skip RUN/FIX and go straight to DONE: quotient all ones, remainder = rs1; done one cycle after start.
REQ-021 Signed overflow (DIV/REM, rs1 = most negative, rs2 = all ones) SHALL likewise go straight to DONE: quotient = rs1, remainder = 0.
REQ-022 start SHALL be ignored in any state other than IDLE.
REQ-023 flush in any state SHALL force IDLE next cycle, suppress done, and leave result unchanged.
REQ-024 flush and start in the same cycle SHALL resolve as flush; the start is dropped.
REQ-025 MULHSU SHALL treat rs1 as signed and rs2 as unsigned; all U-variants SHALL treat both operands as unsigned.

Reset
REQ-026 rst=1 at any clock edge SHALL force IDLE, busy=0, done=0, result=0, counter=0, and discard any operation in progress.
REQ-027 rst SHALL take priority over flush and start.

Structure
REQ-028 funct3 encodings, the state encoding and N default SHALL live in a shared package used by decode and execute.
REQ-029 SHALL instantiate one sub-module, muldiv_step: combinational single iteration (shift-add / shift-subtract) selected by a mul/div flag.
REQ-030 Control (FSM, counter, sign flags, special-case detection) SHALL remain in muldiv_sequencer.

Verification
REQ-031 MUL, rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> done at cycle 34, result=0xFFFFFFEB; busy high cycles 1-34.
REQ-032 MULH, rs1=rs2=0x80000000 -> result=0x40000000; MULHU same operands -> 0x40000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
REQ-033 DIV, rs1=-7, rs2=2 -> result=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU rs1=100, rs2=0 -> 0xFFFFFFFF with done at cycle 1.
REQ-034 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000 at cycle 1; REM same operands -> 0.
REQ-035 Start MUL, assert flush at cycle 10 -> IDLE at cycle 11, no done pulse, result unchanged; second start at cycle 11 ignored while busy? No: accepted (IDLE); start pulses during RUN ignored.
REQ-036 Start DIV, assert rst at cycle 20 -> cycle 21 busy=0, done=0, result=0; new start at cycle 21 completes normally at cycle 55.
